// File: rtl/tick_div_pkg.sv
// Shared constants and helpers for the tick_divider block.
package tick_div_pkg;

  localparam int DEF_CNT_W = 32;
  localparam int DEF_DIV   = 1000000;

  // Length of the high phase of the square enable for divisor n.
  function automatic logic [DEF_CNT_W-1:0] half(input logic [DEF_CNT_W-1:0] n);
    return n >> 1;
  endfunction

endpackage

// File: rtl/tick_div_chan.sv
// One divider channel: period counter, active/shadow divisor, tick and square outputs.
module tick_div_chan
  import tick_div_pkg::*;
#(
  parameter int               CNT_W   = DEF_CNT_W,
  parameter logic [CNT_W-1:0] RST_DIV = CNT_W'(DEF_DIV)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             sync,
  input  logic             ld,
  input  logic [CNT_W-1:0] ld_val,
  output logic             tick,
  output logic             sq
);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] div_act_q, div_act_d;
  logic [CNT_W-1:0] div_shd_q, div_shd_d;
  logic             pend_q, pend_d;
  logic             tick_q, tick_d;
  logic             sq_q, sq_d;
  logic             wrap;
  logic             half_hit;
  logic [CNT_W-1:0] half_v;

  assign half_v   = CNT_W'(half(DEF_CNT_W'(div_act_q)));
  assign wrap     = (cnt_q == div_act_q - CNT_W'(1));
  assign half_hit = (cnt_q == half_v - CNT_W'(1));

  always_comb begin
    cnt_d     = cnt_q;
    div_act_d = div_act_q;
    div_shd_d = div_shd_q;
    pend_d    = pend_q;
    tick_d    = 1'b0;
    sq_d      = sq_q;
    if (sync) begin
      cnt_d  = '0;
      pend_d = 1'b0;
      if (pend_q) div_act_d = div_shd_q;
      if (en) begin
        tick_d = 1'b1;
        sq_d   = 1'b1;
      end
    end else if (en) begin
      if (wrap) begin
        cnt_d  = '0;
        tick_d = 1'b1;
        sq_d   = 1'b1;
        pend_d = 1'b0;
        if (pend_q) div_act_d = div_shd_q;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
        if (half_hit) sq_d = 1'b0;
      end
    end
    // A write on a wrap/sync edge lands after the old pending value was consumed.
    if (ld) begin
      div_shd_d = ld_val;
      pend_d    = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q     <= '0;
      div_act_q <= RST_DIV;
      div_shd_q <= RST_DIV;
      pend_q    <= 1'b0;
      tick_q    <= 1'b0;
      sq_q      <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      div_act_q <= div_act_d;
      div_shd_q <= div_shd_d;
      pend_q    <= pend_d;
      tick_q    <= tick_d;
      sq_q      <= sq_d;
    end
  end

  assign tick = tick_q;
  assign sq   = sq_q;

endmodule

// File: rtl/tick_divider.sv
// Multi-channel programmable tick / square clock-enable generator with divisor write port.
module tick_divider
  import tick_div_pkg::*;
#(
  parameter int          CHANNELS    = 2,
  parameter int          CNT_W       = DEF_CNT_W,
  parameter int unsigned DEFAULT_DIV = DEF_DIV,
  parameter int          SEL_W       = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [CHANNELS-1:0] en,
  input  logic                sync,
  input  logic                div_wr,
  input  logic [SEL_W-1:0]    div_sel,
  input  logic [CNT_W-1:0]    div_data,
  output logic [CHANNELS-1:0] tick,
  output logic [CHANNELS-1:0] sq,
  output logic                div_err
);

  logic                sel_ok;
  logic                data_ok;
  logic                wr_ok;
  logic [CHANNELS-1:0] ld;
  logic                div_err_q, div_err_d;

  // div_wr is a single-cycle strobe with no ready: every edge it is high is one write.
  always_comb begin
    sel_ok    = (32'(div_sel) < 32'(CHANNELS));
    data_ok   = (div_data != '0);
    wr_ok     = div_wr && sel_ok && data_ok;
    div_err_d = div_err_q || (div_wr && !(sel_ok && data_ok));
    for (int i = 0; i < CHANNELS; i++) begin
      ld[i] = wr_ok && (32'(div_sel) == 32'(i));
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) div_err_q <= 1'b0;
    else        div_err_q <= div_err_d;
  end

  assign div_err = div_err_q;

  for (genvar g = 0; g < CHANNELS; g++) begin : g_chan
    tick_div_chan #(
      .CNT_W  (CNT_W),
      .RST_DIV(CNT_W'(DEFAULT_DIV))
    ) u_chan (
      .clk   (clk),
      .rst_n (rst_n),
      .en    (en[g]),
      .sync  (sync),
      .ld    (ld[g]),
      .ld_val(div_data),
      .tick  (tick[g]),
      .sq    (sq[g])
    );
  end

endmodule

// File: tb/tb_tick_divider.sv
// Bench for tick_divider: stimulus table, directed corner sequences and random traffic vs. a period model.
module tb_tick_divider;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [1:0] en = 2'b00;
  logic       sync = 1'b0;
  logic       div_wr = 1'b0;
  logic       div_sel = 1'b0;
  logic [7:0] div_data = 8'd0;
  logic [1:0] tick, sq;
  logic       div_err;

  logic [2:0] en3 = 3'b000;
  logic       sync3 = 1'b0;
  logic       wr3 = 1'b0;
  logic [1:0] sel3 = 2'd0;
  logic [7:0] data3 = 8'd0;
  logic [2:0] tick3, sq3;
  logic       err3;

  tick_divider #(.CHANNELS(2), .CNT_W(8), .DEFAULT_DIV(4)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .sync(sync), .div_wr(div_wr),
    .div_sel(div_sel), .div_data(div_data), .tick(tick), .sq(sq), .div_err(div_err)
  );

  tick_divider #(.CHANNELS(3), .CNT_W(8), .DEFAULT_DIV(4)) dut3 (
    .clk(clk), .rst_n(rst_n), .en(en3), .sync(sync3), .div_wr(wr3),
    .div_sel(sel3), .div_data(data3), .tick(tick3), .sq(sq3), .div_err(err3)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;
  int edge_n = 0;

  // Reference: each channel tracks elapsed enabled cycles in its current period.
  int         m_e[2];
  int         m_per[2];
  int         m_shd[2];
  bit         m_pend[2];
  logic [1:0] m_tick, m_sq;
  logic       m_err;
  logic [4:0] exp_q[$];

  typedef struct {
    logic [1:0] en;
    logic       sync;
    logic       wr;
    logic       sel;
    logic [7:0] data;
    logic [1:0] tick;
    logic [1:0] sq;
  } vec_t;

  vec_t tbl[24];

  task automatic cmp(input string name, input int act, input int exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s edge=%0d got=%0h want=%0h", name, edge_n, act, exp);
    end
  endtask

  task automatic model_reset();
    for (int c = 0; c < 2; c++) begin
      m_e[c] = 0; m_per[c] = 4; m_shd[c] = 4; m_pend[c] = 1'b0;
    end
    m_tick = 2'b00; m_sq = 2'b00; m_err = 1'b0;
    exp_q.delete();
  endtask

  task automatic start_period(input int c);
    m_e[c] = 0;
    m_tick[c] = 1'b1;
    m_sq[c] = 1'b1;
    if (m_pend[c]) m_per[c] = m_shd[c];
    m_pend[c] = 1'b0;
  endtask

  task automatic model_step(input logic [1:0] e, input logic s, input logic w,
                            input logic sel, input logic [7:0] d);
    for (int c = 0; c < 2; c++) begin
      if (s) begin
        if (e[c]) start_period(c);
        else begin
          m_e[c] = 0; m_tick[c] = 1'b0;
          if (m_pend[c]) m_per[c] = m_shd[c];
          m_pend[c] = 1'b0;
        end
      end else if (!e[c]) begin
        m_tick[c] = 1'b0;
      end else begin
        m_e[c] = m_e[c] + 1;
        if (m_e[c] == m_per[c]) start_period(c);
        else begin
          m_tick[c] = 1'b0;
          if (m_e[c] == m_per[c] / 2) m_sq[c] = 1'b0;
        end
      end
    end
    if (w) begin
      if (d == 8'd0) m_err = 1'b1;
      else begin
        m_shd[int'(sel)] = int'(d);
        m_pend[int'(sel)] = 1'b1;
      end
    end
    exp_q.push_back({m_err, m_sq, m_tick});
  endtask

  task automatic check_model();
    logic [4:0] x;
    if (exp_q.size() == 0) begin
      cmp("mdl_queue_empty", 1, 0);
      return;
    end
    x = exp_q.pop_front();
    cmp("mdl_tick", int'(tick), int'(x[1:0]));
    cmp("mdl_sq", int'(sq), int'(x[3:2]));
    cmp("mdl_err", int'(div_err), int'(x[4]));
  endtask

  task automatic step(input logic [1:0] e, input logic s, input logic w,
                      input logic sel, input logic [7:0] d);
    @(negedge clk);
    en = e; sync = s; div_wr = w; div_sel = sel; div_data = d;
    model_step(e, s, w, sel, d);
    @(posedge clk);
    #1;
    edge_n++;
    check_model();
  endtask

  initial begin
    tbl = '{
      '{2'b11, 1'b0, 1'b0, 1'b0, 8'd0, 2'b00, 2'b00},
      '{2'b11, 1'b0, 1'b0, 1'b0, 8'd0, 2'b00, 2'b00},
      '{2'b11, 1'b0, 1'b0, 1'b0, 8'd0, 2'b00, 2'b00},
      '{2'b11, 1'b0, 1'b0, 1'b0, 8'd0, 2'b11, 2'b11},
      '{2'b11, 1'b0, 1'b0, 1'b0, 8'd0, 2'b00, 2'b11},
      '{2'b11, 1'b0, 1'b0, 1'b0, 8'd0, 2'b00, 2'b00},
      '{2'b11, 1'b0, 1'b0, 1'b0, 8'd0, 2'b00, 2'b00},
      '{2'b11, 1'b0, 1'b0, 1'b0, 8'd0, 2'b11, 2'b11},
      '{2'b11, 1'b0, 1'b0, 1'b0, 8'd0, 2'b00, 2'b11},
      '{2'b11, 1'b0, 1'b0, 1'b0, 8'd0, 2'b00, 2'b00},
      '{2'b11, 1'b0, 1'b0, 1'b0, 8'd0, 2'b00, 2'b00},
      '{2'b11, 1'b0, 1'b0, 1'b0, 8'd0, 2'b11, 2'b11},
      '{2'b11, 1'b0, 1'b1, 1'b1, 8'd3, 2'b00, 2'b11},
      '{2'b11, 1'b0, 1'b0, 1'b0, 8'd0, 2'b00, 2'b00},
      '{2'b11, 1'b0, 1'b0, 1'b0, 8'd0, 2'b00, 2'b00},
      '{2'b11, 1'b0, 1'b0, 1'b0, 8'd0, 2'b11, 2'b11},
      '{2'b11, 1'b0, 1'b0, 1'b0, 8'd0, 2'b00, 2'b01},
      '{2'b11, 1'b0, 1'b0, 1'b0, 8'd0, 2'b00, 2'b00},
      '{2'b11, 1'b0, 1'b0, 1'b0, 8'd0, 2'b10, 2'b10},
      '{2'b11, 1'b0, 1'b0, 1'b0, 8'd0, 2'b01, 2'b01},
      '{2'b11, 1'b0, 1'b0, 1'b0, 8'd0, 2'b00, 2'b01},
      '{2'b11, 1'b0, 1'b0, 1'b0, 8'd0, 2'b10, 2'b10},
      '{2'b11, 1'b0, 1'b0, 1'b0, 8'd0, 2'b00, 2'b00},
      '{2'b11, 1'b0, 1'b0, 1'b0, 8'd0, 2'b01, 2'b01}
    };

    // Clock/reset
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    cmp("rst_tick", int'(tick), 0);
    cmp("rst_sq", int'(sq), 0);
    cmp("rst_err", int'(div_err), 0);
    rst_n = 1'b1;

    // Release, default period 4; then ch1 reprogrammed to 3 mid-period
    for (int i = 0; i < 24; i++) begin
      step(tbl[i].en, tbl[i].sync, tbl[i].wr, tbl[i].sel, tbl[i].data);
      cmp("tbl_tick", int'(tick), int'(tbl[i].tick));
      cmp("tbl_sq", int'(sq), int'(tbl[i].sq));
      cmp("tbl_err", int'(div_err), 0);
    end

    // Write N=6 to ch0 on its wrap edge (28): one more 4-cycle period, then 6
    for (int k = 25; k <= 44; k++) begin
      int ph;
      int per;
      per = (k < 32) ? 4 : 6;
      ph = (k < 32) ? (k - 24) % 4 : (k - 32) % 6;
      step(2'b11, 1'b0, (k == 28), 1'b0, 8'd6);
      cmp("wrapwr_tick0", int'(tick[0]), int'(ph == 0));
      cmp("wrapwr_sq0", int'(sq[0]), int'(ph < per / 2));
    end

    // N=1 then N=2 on ch0, applied via sync
    step(2'b11, 1'b0, 1'b1, 1'b0, 8'd1);
    for (int k = 46; k <= 51; k++) begin
      step(2'b11, (k == 46), 1'b0, 1'b0, 8'd0);
      cmp("n1_tick0", int'(tick[0]), 1);
      cmp("n1_sq0", int'(sq[0]), 1);
    end
    step(2'b11, 1'b0, 1'b1, 1'b0, 8'd2);
    for (int k = 53; k <= 58; k++) begin
      step(2'b11, (k == 53), 1'b0, 1'b0, 8'd0);
      cmp("n2_tick0", int'(tick[0]), int'((k - 53) % 2 == 0));
      cmp("n2_sq0", int'(sq[0]), int'((k - 53) % 2 == 0));
    end

    // Bad writes: N=0 here, out-of-range select on the three-channel instance
    wr3 = 1'b1; sel3 = 2'd2; data3 = 8'd5;
    step(2'b11, 1'b0, 1'b1, 1'b0, 8'd0);
    cmp("err_zero", int'(div_err), 1);
    cmp("err3_sel2_ok", int'(err3), 0);
    sel3 = 2'd3;
    step(2'b11, 1'b0, 1'b1, 1'b0, 8'd3);
    cmp("err3_sel3", int'(err3), 1);
    wr3 = 1'b0;
    cmp("ch3_idle", int'({tick3, sq3}), 0);
    step(2'b11, 1'b1, 1'b0, 1'b0, 8'd0);
    cmp("sync_tick", int'(tick), 3);
    for (int j = 1; j <= 9; j++) begin
      step(2'b11, 1'b0, 1'b0, 1'b0, 8'd0);
      cmp("aligned_tick", int'(tick), (j % 3 == 0) ? 3 : 0);
    end
    cmp("err_sticky", int'(div_err), 1);

    // Freeze ch0 mid-period, then resume
    step(2'b11, 1'b0, 1'b1, 1'b0, 8'd6);
    step(2'b11, 1'b1, 1'b0, 1'b0, 8'd0);
    step(2'b11, 1'b0, 1'b0, 1'b0, 8'd0);
    for (int j = 0; j < 5; j++) begin
      step(2'b10, 1'b0, 1'b0, 1'b0, 8'd0);
      cmp("frz_tick0", int'(tick[0]), 0);
      cmp("frz_sq0", int'(sq[0]), 1);
    end
    for (int j = 1; j <= 5; j++) begin
      step(2'b11, 1'b0, 1'b0, 1'b0, 8'd0);
      cmp("resume_tick0", int'(tick[0]), int'(j == 5));
      cmp("resume_sq0", int'(sq[0]), int'(j == 1 || j == 5));
    end

    // Async reset mid-period with a pending ch1 write that must be lost
    step(2'b11, 1'b0, 1'b1, 1'b1, 8'd5);
    step(2'b11, 1'b0, 1'b0, 1'b0, 8'd0);
    #3;
    rst_n = 1'b0;
    #1;
    cmp("arst_tick", int'(tick), 0);
    cmp("arst_sq", int'(sq), 0);
    cmp("arst_err", int'(div_err), 0);
    en = 2'b00; sync = 1'b0; div_wr = 1'b0;
    model_reset();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    edge_n = 0;
    for (int k = 1; k <= 8; k++) begin
      step(2'b11, 1'b0, 1'b0, 1'b0, 8'd0);
      cmp("rerst_tick", int'(tick), (k % 4 == 0) ? 3 : 0);
    end

    // Random traffic against the model
    for (int i = 0; i < 400; i++) begin
      logic [1:0] e;
      logic [7:0] d;
      e[0] = ($urandom_range(0, 3) != 0);
      e[1] = ($urandom_range(0, 3) != 0);
      d = ($urandom_range(0, 15) == 0) ? 8'd0 : 8'($urandom_range(1, 7));
      step(e, ($urandom_range(0, 19) == 0), ($urandom_range(0, 7) == 0),
           1'($urandom_range(0, 1)), d);
    end
    div_wr = 1'b0;

    // Final report
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
